seq_divider: RTL and testbench

Multi-cycle restoring integer divider with valid/ready handshakes on both sides. It is the inverse arithmetic unit of the existing add/sub datapath: the adder produces sums and differences in one cycle, and this block recovers quotient and remainder by iterated subtraction, one quotient bit per cycle. It sits beside the adder in the arithmetic datapath and shares its clock and reset.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_div_step.sv | 25 ++
 rtl/seq_divider.sv | 154 +++++++++++++++
 tb/tb_seq_divider.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The incoming remainder is always below the divisor, so bit WIDTH of the trial is the borrow.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_bit_o = ~trial[WIDTH];
    rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with valid/ready handshakes; one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands and results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] dvd_in, dsr_in;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;

  // Core sees magnitudes; signs captured at accept are reapplied in the finishing cycle.
  always_comb begin
    dvd_in  = dividend[WIDTH-1] ? -dividend : dividend;
    dsr_in  = divisor[WIDTH-1] ? -divisor : divisor;
    quo_fix = q_neg_q ? -dvd_q : dvd_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (state_q == IDLE && in_valid) begin
      q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end
`else
  assign dvd_in  = dividend;
  assign dsr_in  = divisor;
  assign quo_fix = dvd_q;
  assign rem_fix = rem_q;
`endif

  // Every operation ends with one CALC cycle at count 0 that registers the results;
  // a zero divisor enters CALC with count 0 so it finishes one edge after accept.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rout_d  = rout_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          zero_d  = (divisor == '0);
          count_d = (divisor == '0) ? '0 : CW'(WIDTH);
          dvd_d   = (divisor == '0) ? dividend : dvd_in;
          dsr_d   = dsr_in;
          rem_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (count_q != '0) begin
          rem_d   = step_rem;
          dvd_d   = {dvd_q[WIDTH-2:0], step_bit};
          count_d = count_q - CW'(1);
        end else begin
          quo_d   = zero_q ? '1 : quo_fix;
          rout_d  = zero_q ? dvd_q : rem_fix;
          dbz_d   = zero_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rout_q  <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rout_q  <= rout_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rout_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard testbench for seq_divider: expected results queued at accept, checked at output.
module tb_seq_divider;

   localparam int W = 8;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           acc;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   exp_t sb[$];
   int   cycle = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   seen = 0;
   bit   expectReady = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock and an edge counter used to measure latency.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Counts every comparison and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic, independent of the restoring algorithm.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
`ifdef SEQ_DIVIDER_SIGNED_EN
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sbv;
      sa = a;
      sbv = b;
`endif
      e.acc = 0;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
         e.dbz = 1'b1;
      end else begin
         e.dbz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         if (a == MIN_NEG && b == '1) begin
            e.q = MIN_NEG;
            e.r = '0;
         end else begin
            e.q = W'(sa / sbv);
            e.r = W'(sa % sbv);
         end
`else
         e.q = a / b;
         e.r = a % b;
`endif
      end
      return e;
   endfunction

   // Offers one operation and pushes its expected result once it is accepted.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   n;
      bit   ok;
      ok = 1'b0;
      n = 0;
      dividend = a;
      divisor = b;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin
            n = cycle;
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checkOutput("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         #1;
         in_valid = 1'b0;
         e = model(a, b);
         e.acc = n + 1;
         sb.push_back(e);
      end
   endtask

   // Waits until every queued result has been delivered and the block is idle again.
   task automatic waitDrain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0 && in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Output monitor: latency at the rising edge of out_valid, stable results while held,
   // pop on handshake, and in_ready back one edge after the handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
         expectReady = 1'b0;
      end else begin
         if (expectReady) begin
            checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
            expectReady = 1'b0;
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  checkOutput("latency", 32'(cycle - sb[0].acc), sb[0].dbz ? 32'd1 : 32'(W + 1));
               end
               checkOutput("quotient", 32'(quotient), 32'(sb[0].q));
               checkOutput("remainder", 32'(remainder), 32'(sb[0].r));
               checkOutput("div_by_zero", 32'(div_by_zero), 32'(sb[0].dbz));
               checkOutput("in_ready_while_done", 32'(in_ready), 32'd0);
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen = 1'b0;
                  expectReady = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      dividend = '0;
      divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_quotient", 32'(quotient), 32'd0);
      checkOutput("reset_remainder", 32'(remainder), 32'd0);
      checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic division and divide by zero");
      applyStimulus(8'd200, 8'd7);
      waitDrain();
      applyStimulus(8'd5, 8'd0);
      waitDrain();

      $display("[TB] back to back with in_valid during CALC");
      applyStimulus(8'd255, 8'd1);
      dividend = 8'hAA;
      divisor = 8'h03;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(8'd3, 8'd200);
      waitDrain();

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(8'd100, 8'd9);
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         @(posedge clk);
         #1;
      end
      if (!out_valid) checkOutput("backpressure_timeout", 32'(out_valid), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitDrain();

      $display("[TB] reset during CALC");
      applyStimulus(8'd50, 8'd7);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      sb.delete();
      checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset_quotient", 32'(quotient), 32'd0);
      checkOutput("midreset_remainder", 32'(remainder), 32'd0);
      checkOutput("midreset_div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(8'd10, 8'd3);
      waitDrain();

`ifdef SEQ_DIVIDER_SIGNED_EN
      $display("[TB] signed corner cases");
      applyStimulus(8'hF9, 8'h02);
      waitDrain();
      applyStimulus(8'h80, 8'hFF);
      waitDrain();
      applyStimulus(8'h80, 8'h00);
      waitDrain();
`endif

      $display("[TB] random operations");
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         applyStimulus(a, b);
      end
      applyStimulus(MIN_NEG, 8'd1);
      applyStimulus(8'd1, 8'd255);
      waitDrain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
